// File: rtl/mux_pkg.sv
// Shared types and select-width helper for the NUM_IN:1 selector family.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int MUX_DEF_WIDTH  = 64;
  localparam int MUX_DEF_NUM_IN = 4;

  // A 2-input selector still needs one select bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n1.sv
// Combinational NUM_IN:1 selector, zero word on an out-of-range select.
// Latency: 0 cycles.
// Backpressure: none (pure combinational).
module mux_n1
  import mux_pkg::*;
#(
  parameter int WIDTH  = MUX_DEF_WIDTH,
  parameter int NUM_IN = MUX_DEF_NUM_IN,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        dout
);

  always_comb begin
    dout = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) dout = din[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_nsel_skid.sv
// NUM_IN:1 selector feeding a registered 2-entry skid buffer; MUX_SEL_CHECK_EN adds a sticky bad-select flag.
// Latency: word accepted in cycle N is on out_data in cycle N+1; one word/cycle sustained.
// Backpressure: in_ready comes from registered occupancy only and drops while the skid entry is full.
module mux_nsel_skid
  import mux_pkg::*;
#(
  parameter int WIDTH  = MUX_DEF_WIDTH,
  parameter int NUM_IN = MUX_DEF_NUM_IN,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q, sel_word;
  logic             accept, pop, skid_vld;
  logic             load_main, load_skid, main_from_skid;

  mux_n1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
    .din  (in_data),
    .sel  (in_sel),
    .dout (sel_word)
  );

  assign skid_vld  = (state_q == FULL);
  assign in_ready  = ~skid_vld & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything, including a word accepted this same cycle.
    if (flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= sel_word;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= sel_word;
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic in_range;
  logic sel_err_q;

  assign in_range = ({1'b0, in_sel} < (SEL_W+1)'(NUM_IN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     sel_err_q <= 1'b0;
    else if (accept && !in_range)  sel_err_q <= 1'b1;
  end

  assign sel_err = sel_err_q;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(accept && !in_range))
        else $error("mux_nsel_skid: out-of-range select %0d accepted", in_sel);
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nsel_skid.sv
// Randomised scoreboard bench for mux_nsel_skid (NUM_IN=4 main instance, NUM_IN=3 for bad selects).
module tb_mux_nsel_skid;

  localparam logic EXP_ERR =
`ifdef MUX_SEL_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         flush;
  logic [255:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         sel_err;

  logic         flush3;
  logic [191:0] in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [63:0]  out_data3;
  logic         out_valid3;
  logic         out_ready3;
  logic         sel_err3;

  logic [63:0]  words  [4];
  logic [63:0]  words3 [3];
  logic [63:0]  q [$];

  int checks = 0;
  int errors = 0;

  mux_nsel_skid #(.WIDTH(64), .NUM_IN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  mux_nsel_skid #(.WIDTH(64), .NUM_IN(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush3),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .sel_err   (sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int k = 0; k < 4; k++) in_data[k*64 +: 64] = words[k];
  end

  always_comb begin
    in_data3 = '0;
    for (int k = 0; k < 3; k++) in_data3[k*64 +: 64] = words3[k];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: the block is a 2-deep FIFO of selected words.
  function automatic logic [63:0] model_word(input int sel);
    return (sel < 4) ? words[sel] : 64'd0;
  endfunction

  // Record what the DUT should have taken this cycle, then advance to just after the next edge.
  task automatic cyc();
    @(negedge clk);
    #1;
    if (!reset && in_valid && in_ready) q.push_back(model_word(int'(in_sel)));
    if (flush) q.delete();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the model queue every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
      end else begin
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
          chk("head_data", out_data, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      chk("sel_err_pow2", 64'(sel_err), 64'd0);
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0;
    flush3 = 1'b0; in_sel3 = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    for (int k = 0; k < 4; k++) words[k] = '0;
    words3[0] = 64'd7; words3[1] = 64'd8; words3[2] = 64'd9;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Select sweep: one word per cycle, each visible the cycle after accept.
    words[0] = 64'd10; words[1] = 64'd20; words[2] = 64'd30; words[3] = 64'd40;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      cyc();
      chk("sweep_data", out_data, 64'(10 * (s + 1)));
      chk("sweep_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    cyc();

    // Back-pressure: two words fill the buffer, then drain in order.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    words[0] = 64'd5;
    cyc();
    chk("bp_ready_after_1", 64'(in_ready), 64'd1);
    words[0] = 64'd6;
    cyc();
    chk("bp_ready_after_2", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    cyc();
    chk("bp_hold", out_data, 64'd5);
    out_ready = 1'b1;
    cyc();
    chk("bp_second", out_data, 64'd6);
    cyc();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush while full with a word offered.
    out_ready = 1'b0; in_valid = 1'b1;
    words[0] = 64'd100; cyc();
    words[0] = 64'd101; cyc();
    words[0] = 64'd102; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc();
    chk("flush_no_emit", 64'(out_valid), 64'd0);

    // Reset mid-stream with the buffer full.
    out_ready = 1'b0; in_valid = 1'b1;
    words[0] = 64'd200; cyc();
    words[0] = 64'd201; cyc();
    chk("full_before_reset", 64'(in_ready), 64'd0);
    reset = 1'b1; in_valid = 1'b0;
    q.delete();
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", out_data, 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd0);
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_valid", 64'(out_valid), 64'd0);
    cyc();

    // Random stress against the model queue.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 63) == 0);
      in_sel    = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) words[k] = {$urandom(), $urandom()};
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("drain_empty", 64'(q.size()), 64'd0);

    // Out-of-range select on a 3-input instance.
    chk("n3_ready", 64'(in_ready3), 64'd1);
    chk("n3_err_initial", 64'(sel_err3), 64'd0);
    out_ready3 = 1'b1; in_valid3 = 1'b1; in_sel3 = 2'd3;
    cyc();
    chk("n3_bad_valid", 64'(out_valid3), 64'd1);
    chk("n3_bad_data", out_data3, 64'd0);
    chk("n3_err_set", 64'(sel_err3), 64'(EXP_ERR));
    in_sel3 = 2'd2;
    cyc();
    chk("n3_good_data", out_data3, 64'd9);
    chk("n3_err_sticky", 64'(sel_err3), 64'(EXP_ERR));
    in_valid3 = 1'b0;
    cyc();
    chk("n3_idle_valid", 64'(out_valid3), 64'd0);
    chk("n3_err_sticky2", 64'(sel_err3), 64'(EXP_ERR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
